// File: rtl/systolic_stream_ctrl.sv
// Front-end controller for an N x N systolic array. It buffers the host weight and activation tiles,
// fetches both tiles, publishes the weights, and feeds the activations into the rows with a diagonal skew.
module systolic_stream_ctrl #(
  parameter int N         = 4,
  parameter int DW        = 32,
  parameter int AW        = $clog2(N*N),
  parameter int DRAIN_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mem_we,
  input  logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         weight_din,
  input  logic [DW-1:0]         act_din,
  output logic [N*DW-1:0]       act_row_out,
  output logic [N-1:0]          act_valid,
  output logic [N*N*DW-1:0]     weight_flat_out,
  output logic                  weight_valid,
  output logic                  busy,
  output logic                  done
);
  localparam int NN = N*N;
  localparam int FW = $clog2(NN+1);
  localparam int CW = $clog2(2*N);
  localparam logic [FW-1:0] F_LAST = FW'(NN);
  localparam logic [CW-1:0] C_LAST = CW'(2*N-1);
  localparam logic [7:0]    D_LAST = 8'(DRAIN_CYC-1);

  typedef enum logic [2:0] {IDLE, FETCH, EXECUTE, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   f;
  logic [CW-1:0]   c;
  logic [7:0]      d;
  logic [DW-1:0]   wmem [NN];
  logic [DW-1:0]   amem [NN];
  logic [DW-1:0]   act_reg [NN];
  logic [DW-1:0]   w_rd_p1, a_rd_p1;
  logic [AW-1:0]   cap_idx;
  logic [N*DW-1:0] row_nxt;
  logic [N-1:0]    vld_nxt;
  logic            kill;

  function automatic logic [AW-1:0] feed_idx(input logic [CW-1:0] cnt, input int r);
    return AW'((int'(cnt) - r) * N + r);
  endfunction

  assign kill    = abort && (state != IDLE);
  assign cap_idx = AW'(f - FW'(1));
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // Stage p0 -> p1: tile memories, host writes accepted only while idle
  always_ff @(posedge clk) begin
    if (mem_we && state == IDLE) begin
      wmem[mem_addr] <= weight_din;
      amem[mem_addr] <= act_din;
    end
    if (state == FETCH && f < F_LAST) begin
      w_rd_p1 <= wmem[f[AW-1:0]];
      a_rd_p1 <= amem[f[AW-1:0]];
    end
    if (state == FETCH && f != '0 && !abort)
      act_reg[cap_idx] <= a_rd_p1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (f == F_LAST) state_nxt = EXECUTE;
      EXECUTE: if (c == C_LAST) state_nxt = DRAIN;
      DRAIN:   if (d == D_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // Row r carries act[k*N + r] while k = c - r lies in 0..N-1
  always_comb begin
    row_nxt = '0;
    vld_nxt = '0;
    for (int r = 0; r < N; r++) begin
      if (int'(c) >= r && int'(c) - r < N) begin
        row_nxt[r*DW +: DW] = act_reg[feed_idx(c, r)];
        vld_nxt[r]          = 1'b1;
      end
    end
  end

  // Stage p1 -> p2: capture fetched words, drive the skewed row outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      f               <= '0;
      c               <= '0;
      d               <= '0;
      act_row_out     <= '0;
      act_valid       <= '0;
      weight_flat_out <= '0;
      weight_valid    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (kill) begin
        act_row_out  <= '0;
        act_valid    <= '0;
        weight_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              f            <= '0;
              weight_valid <= 1'b0;
            end
          end
          FETCH: begin
            if (f != '0)
              weight_flat_out[int'(cap_idx)*DW +: DW] <= w_rd_p1;
            if (f == F_LAST) begin
              weight_valid <= 1'b1;
              c            <= '0;
            end else begin
              f <= f + FW'(1);
            end
          end
          EXECUTE: begin
            act_row_out <= row_nxt;
            act_valid   <= vld_nxt;
            if (c == C_LAST) d <= '0;
            else             c <= c + CW'(1);
          end
          DRAIN: begin
            act_row_out <= '0;
            act_valid   <= '0;
            if (d != D_LAST) d <= d + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_systolic_stream_ctrl.sv
// Directed bench for systolic_stream_ctrl: an N=4 instance driven from a vector table, plus an N=8/DW=16 instance.
module tb_systolic_stream_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 0, abort = 0, mem_we = 0;
  logic [3:0]    mem_addr = '0;
  logic [31:0]   weight_din = '0, act_din = '0;
  logic [127:0]  act_row_out;
  logic [3:0]    act_valid;
  logic [511:0]  weight_flat_out;
  logic          weight_valid, busy, done;

  logic          start8 = 0, abort8 = 0, mem_we8 = 0;
  logic [5:0]    addr8 = '0;
  logic [15:0]   wd8 = '0, ad8 = '0;
  logic [127:0]  row8;
  logic [7:0]    vld8;
  logic [1023:0] wflat8;
  logic          wv8, busy8, done8;

  systolic_stream_ctrl #(.N(4), .DW(32), .DRAIN_CYC(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mem_we(mem_we),
    .mem_addr(mem_addr), .weight_din(weight_din), .act_din(act_din),
    .act_row_out(act_row_out), .act_valid(act_valid), .weight_flat_out(weight_flat_out),
    .weight_valid(weight_valid), .busy(busy), .done(done));

  systolic_stream_ctrl #(.N(8), .DW(16), .DRAIN_CYC(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8), .mem_we(mem_we8),
    .mem_addr(addr8), .weight_din(wd8), .act_din(ad8),
    .act_row_out(row8), .act_valid(vld8), .weight_flat_out(wflat8),
    .weight_valid(wv8), .busy(busy8), .done(done8));

  typedef struct {
    int               c;
    logic [3:0][31:0] row;
    logic [3:0]       vld;
  } vec_t;
  vec_t tbl [8];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr4(input int a, input logic [31:0] w, input logic [31:0] x);
    mem_we = 1; mem_addr = 4'(a); weight_din = w; act_din = x;
    step();
    mem_we = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk(name, 1024'(busy), 1024'(0));
  endtask

  // Full N=4 run with act[i]=i+1, weight[i]=0x100+i preloaded; a write is attempted mid-run
  task automatic run_full(input string tag);
    int d0;
    d0 = done_cnt;
    start = 1;
    step();
    start = 0;
    chk({tag, "_busy"}, 1024'(busy), 1024'(1));
    repeat (16) step();
    chk({tag, "_wv_e16"}, 1024'(weight_valid), 1024'(0));
    step();
    chk({tag, "_wv_e17"}, 1024'(weight_valid), 1024'(1));
    chk({tag, "_w5"}, 1024'(weight_flat_out[5*32 +: 32]), 1024'(32'h105));
    chk({tag, "_w15"}, 1024'(weight_flat_out[15*32 +: 32]), 1024'(32'h10F));
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_row_c%0d", tag, tbl[i].c), 1024'(act_row_out), 1024'(tbl[i].row));
      chk($sformatf("%s_vld_c%0d", tag, tbl[i].c), 1024'(act_valid), 1024'(tbl[i].vld));
      if (i == 7) chk({tag, "_done_e25"}, 1024'(done), 1024'(0));
      if (i == 2) begin
        mem_we = 1; mem_addr = 4'd0; weight_din = 32'hDEAD; act_din = 32'hDEAD;
      end
      step();
      mem_we = 0;
    end
    chk({tag, "_done_e26"}, 1024'(done), 1024'(1));
    step();
    chk({tag, "_done_e27"}, 1024'(done), 1024'(0));
    chk({tag, "_busy_e27"}, 1024'(busy), 1024'(0));
    chk({tag, "_done_cnt"}, 1024'(done_cnt - d0), 1024'(1));
  endtask

  initial begin
    tbl[0] = '{0, {32'd0,  32'd0,  32'd0,  32'd1 }, 4'b0001};
    tbl[1] = '{1, {32'd0,  32'd0,  32'd2,  32'd5 }, 4'b0011};
    tbl[2] = '{2, {32'd0,  32'd3,  32'd6,  32'd9 }, 4'b0111};
    tbl[3] = '{3, {32'd4,  32'd7,  32'd10, 32'd13}, 4'b1111};
    tbl[4] = '{4, {32'd8,  32'd11, 32'd14, 32'd0 }, 4'b1110};
    tbl[5] = '{5, {32'd12, 32'd15, 32'd0,  32'd0 }, 4'b1100};
    tbl[6] = '{6, {32'd16, 32'd0,  32'd0,  32'd0 }, 4'b1000};
    tbl[7] = '{7, {32'd0,  32'd0,  32'd0,  32'd0 }, 4'b0000};

    #3;
    chk("rst_rows", 1024'(act_row_out), 1024'(0));
    chk("rst_vld", 1024'(act_valid), 1024'(0));
    chk("rst_wflat", 1024'(weight_flat_out), 1024'(0));
    chk("rst_wv", 1024'(weight_valid), 1024'(0));
    chk("rst_busy", 1024'(busy), 1024'(0));
    chk("rst_done", 1024'(done), 1024'(0));
    #9 rst = 0;

    for (int i = 0; i < 16; i++) wr4(i, 32'h100 + 32'(i), 32'(i + 1));
    run_full("run1");
    run_full("run2");

    // Asynchronous reset in the middle of EXECUTE (after E21, c=3)
    start = 1;
    step();
    start = 0;
    repeat (21) step();
    chk("mid_vld_c3", 1024'(act_valid), 1024'(4'b1111));
    #2 rst = 1;
    #1;
    chk("arst_rows", 1024'(act_row_out), 1024'(0));
    chk("arst_vld", 1024'(act_valid), 1024'(0));
    chk("arst_wflat", 1024'(weight_flat_out), 1024'(0));
    chk("arst_wv", 1024'(weight_valid), 1024'(0));
    chk("arst_busy", 1024'(busy), 1024'(0));
    #2 rst = 0;
    step();
    run_full("post_rst");

    // Write and start in the same cycle: the fetch sees the new word
    mem_we = 1; mem_addr = 4'd0; weight_din = 32'h77; act_din = 32'h55; start = 1;
    step();
    mem_we = 0; start = 0;
    repeat (17) step();
    chk("same_w0", 1024'(weight_flat_out[31:0]), 1024'(32'h77));
    step();
    chk("same_row0", 1024'(act_row_out[31:0]), 1024'(32'h55));
    chk("same_vld", 1024'(act_valid), 1024'(4'b0001));
    wait_idle("same_idle");
    wr4(0, 32'h100, 32'd1);

    // Abort at c=2
    begin
      int d0;
      d0 = done_cnt;
      start = 1;
      step();
      start = 0;
      repeat (20) step();
      chk("abort_pre_vld", 1024'(act_valid), 1024'(4'b0111));
      abort = 1;
      step();
      abort = 0;
      chk("abort_busy", 1024'(busy), 1024'(0));
      chk("abort_rows", 1024'(act_row_out), 1024'(0));
      chk("abort_vld", 1024'(act_valid), 1024'(0));
      chk("abort_wv", 1024'(weight_valid), 1024'(0));
      repeat (10) step();
      chk("abort_no_done", 1024'(done_cnt - d0), 1024'(0));
    end
    run_full("post_abort");

    // N=8, DW=16, DRAIN_CYC=3
    for (int i = 0; i < 64; i++) begin
      mem_we8 = 1; addr8 = 6'(i); wd8 = 16'h100 + 16'(i); ad8 = 16'(i + 1);
      step();
    end
    mem_we8 = 0;
    start8 = 1;
    step();
    start8 = 0;
    repeat (65) step();
    chk("n8_wv_e65", 1024'(wv8), 1024'(1));
    chk("n8_w63", 1024'(wflat8[63*16 +: 16]), 1024'(16'h13F));
    repeat (7) step();
    chk("n8_vld7_c6", 1024'(vld8[7]), 1024'(0));
    step();
    chk("n8_vld7_c7", 1024'(vld8[7]), 1024'(1));
    chk("n8_row7_c7", 1024'(row8[7*16 +: 16]), 1024'(16'd8));
    repeat (7) step();
    chk("n8_vld7_c14", 1024'(vld8[7]), 1024'(1));
    chk("n8_row7_c14", 1024'(row8[7*16 +: 16]), 1024'(16'd64));
    step();
    chk("n8_vld7_c15", 1024'(vld8[7]), 1024'(0));
    repeat (2) step();
    chk("n8_done_e83", 1024'(done8), 1024'(0));
    step();
    chk("n8_done_e84", 1024'(done8), 1024'(1));
    step();
    chk("n8_busy_e85", 1024'(busy8), 1024'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
